// File: rtl/mdu_iter_if.sv
// Handshake and result bundle between pipeline control and the
// iterative multiply/divide unit.
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, dz, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, dz, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up in a final cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  // Magnitude of an operand; unsigned operations pass the raw value through.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               dz_pend_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   araw_r;
  logic [WIDTH-1:0]   rem_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               dz_r;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH:0]     sub_s;
  logic               ge_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rmd_s;

  // One datapath step for each algorithm plus the final sign fix-up.
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (b_r[0] ? a_r : {WIDTH{1'b0}})};
    trial_s   = {rem_r, a_r[WIDTH-1]};
    // The borrow of the trial subtraction doubles as the compare result.
    sub_s     = trial_s - {1'b0, b_r};
    ge_s      = ~sub_s[WIDTH];
    if (neg_q_r) begin
      prod_s = -acc_r;
      quo_s  = -a_r;
    end else begin
      prod_s = acc_r;
      quo_s  = a_r;
    end
    if (neg_r_r) begin
      rmd_s = -rem_r;
    end else begin
      rmd_s = rem_r;
    end
  end

  // Control FSM, operand capture, iteration and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      dz_pend_r <= 1'b0;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      araw_r    <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dz_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                is_div_r  <= bus.op[1];
                a_r       <= mag(bus.a, bus.op[0]);
                b_r       <= mag(bus.b, bus.op[0]);
                neg_q_r   <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r_r   <= bus.op[0] & bus.a[WIDTH-1];
                dz_pend_r <= bus.op[1] & (bus.b == {WIDTH{1'b0}});
                araw_r    <= bus.a;
                acc_r     <= {(2*WIDTH){1'b0}};
                rem_r     <= {WIDTH{1'b0}};
                cnt_r     <= CNT_INIT;
                busy_r    <= 1'b1;
                state_r   <= S_CALC;
              end
              3'b100:  hi_r <= bus.a;
              3'b101:  lo_r <= bus.a;
              default: state_r <= S_IDLE;
            endcase
          end
        end
        S_CALC: begin
          if (is_div_r) begin
            rem_r <= ge_s ? sub_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
            a_r   <= {a_r[WIDTH-2:0], ge_s};
          end else begin
            acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
            b_r   <= b_r >> 1;
          end
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= S_FIX;
          end
        end
        S_FIX: begin
          if (!is_div_r) begin
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
          end else if (dz_pend_r) begin
            hi_r <= araw_r;
            lo_r <= {WIDTH{1'b1}};
          end else begin
            hi_r <= rmd_s;
            lo_r <= quo_s;
          end
          dz_r    <= is_div_r & dz_pend_r;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dz   = dz_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter at WIDTH=32 and WIDTH=8.
module tb_mdu_iter;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mdu_iter_if #(.WIDTH(32)) i32 ();
  mdu_iter_if #(.WIDTH(8))  i8 ();

  mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(i32));
  mdu_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one 32-bit op, scramble operands after acceptance, wait for done.
  task automatic op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output logic [31:0] mid_hi, output logic [31:0] mid_lo);
    @(negedge clk);
    i32.start = 1'b1;
    i32.op    = op;
    i32.a     = a;
    i32.b     = b;
    @(posedge clk);
    #1;
    i32.start = 1'b0;
    i32.a     = 32'hDEADBEEF;
    i32.b     = 32'h13579BDF;
    lat    = -1;
    mid_hi = 32'h0;
    mid_lo = 32'h0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 16) begin
        mid_hi = i32.hi;
        mid_lo = i32.lo;
      end
      if (i32.done) begin
        lat = n;
        break;
      end
    end
  endtask

  int          lat;
  int          dones;
  logic [31:0] mh;
  logic [31:0] ml;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    i32.start = 1'b0; i32.op = 3'b000; i32.a = 32'h0; i32.b = 32'h0;
    i8.start  = 1'b0; i8.op  = 3'b000; i8.a  = 8'h0;  i8.b  = 8'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_hi", i32.hi, 32'h0);
    chk("rst_lo", i32.lo, 32'h0);
    chk("rst_busy", 32'(i32.busy), 32'h0);
    chk("rst_done", 32'(i32.done), 32'h0);
    chk("rst8_hilo", {16'h0, i8.hi, i8.lo}, 32'h0);

    // mthi then mtlo on consecutive edges
    @(negedge clk);
    i32.start = 1'b1; i32.op = 3'b100; i32.a = 32'h12345678;
    @(posedge clk);
    #1;
    chk("mthi_busy", 32'({i32.busy, i32.done}), 32'h0);
    i32.op = 3'b101; i32.a = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    i32.start = 1'b0;
    chk("mtlo_busy", 32'({i32.busy, i32.done}), 32'h0);
    chk("mthi_hi", i32.hi, 32'h12345678);
    chk("mtlo_lo", i32.lo, 32'h9ABCDEF0);

    op32(3'b001, 32'hFFFFFFFF, 32'h7, lat, mh, ml);
    chk("mult_lat", 32'(lat), 32'd33);
    chk("mult_hold_hi", mh, 32'h12345678);
    chk("mult_hold_lo", ml, 32'h9ABCDEF0);
    chk("mult_hi", i32.hi, 32'hFFFFFFFF);
    chk("mult_lo", i32.lo, 32'hFFFFFFF9);
    chk("mult_busy", 32'(i32.busy), 32'h0);
    @(posedge clk);
    #1;
    chk("mult_done_pulse", 32'(i32.done), 32'h0);

    op32(3'b000, 32'hFFFFFFFF, 32'h7, lat, mh, ml);
    chk("multu_hi", i32.hi, 32'h00000006);
    chk("multu_lo", i32.lo, 32'hFFFFFFF9);

    op32(3'b011, 32'hFFFFFFF9, 32'h2, lat, mh, ml);
    chk("div_lat", 32'(lat), 32'd33);
    chk("div_lo", i32.lo, 32'hFFFFFFFD);
    chk("div_hi", i32.hi, 32'hFFFFFFFF);
    chk("div_dz", 32'(i32.dz), 32'h0);

    op32(3'b010, 32'd100, 32'd7, lat, mh, ml);
    chk("divu_lo", i32.lo, 32'd14);
    chk("divu_hi", i32.hi, 32'd2);

    op32(3'b010, 32'h55, 32'h0, lat, mh, ml);
    chk("dz_flag", 32'(i32.dz), 32'h1);
    chk("dz_lo", i32.lo, 32'hFFFFFFFF);
    chk("dz_hi", i32.hi, 32'h55);
    @(posedge clk);
    #1;
    chk("dz_clear", 32'(i32.dz), 32'h0);

    op32(3'b011, 32'h80000000, 32'hFFFFFFFF, lat, mh, ml);
    chk("ovf_lo", i32.lo, 32'h80000000);
    chk("ovf_hi", i32.hi, 32'h0);
    chk("ovf_dz", 32'(i32.dz), 32'h0);

    // divu accepted, then multu and mthi requests while busy must be dropped
    @(negedge clk);
    i32.start = 1'b1; i32.op = 3'b010; i32.a = 32'd100; i32.b = 32'd7;
    @(posedge clk);
    #1;
    dones = 0;
    lat   = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n <= 20) begin
        i32.start = 1'b1; i32.op = 3'b000; i32.a = 32'd3; i32.b = 32'd5;
      end else if (n == 21) begin
        i32.start = 1'b1; i32.op = 3'b100; i32.a = 32'hAAAA5555;
      end else begin
        i32.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i32.done) begin
        dones++;
        if (lat < 0) lat = n;
      end
    end
    chk("busy_dones", 32'(dones), 32'd1);
    chk("busy_lat", 32'(lat), 32'd33);
    chk("busy_lo", i32.lo, 32'd14);
    chk("busy_hi", i32.hi, 32'd2);

    // reset at edge 10 of a div abandons it
    @(negedge clk);
    i32.start = 1'b1; i32.op = 3'b011; i32.a = 32'd100; i32.b = 32'd7;
    @(posedge clk);
    #1;
    i32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rstmid_hi", i32.hi, 32'h0);
    chk("rstmid_lo", i32.lo, 32'h0);
    chk("rstmid_busy", 32'(i32.busy), 32'h0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (i32.done) dones++;
    end
    chk("rstmid_nodone", 32'(dones), 32'd0);

    // WIDTH=8 multiply
    @(negedge clk);
    i8.start = 1'b1; i8.op = 3'b001; i8.a = 8'hFF; i8.b = 8'h07;
    @(posedge clk);
    #1;
    i8.start = 1'b0; i8.a = 8'h00; i8.b = 8'h00;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (i8.done) begin
        lat = n;
        break;
      end
    end
    chk("w8_lat", 32'(lat), 32'd9);
    chk("w8_hi", 32'(i8.hi), 32'h000000FF);
    chk("w8_lo", 32'(i8.lo), 32'h000000F9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
